// File: rtl/uart_wb_arbiter.sv
// Two-master round-robin WISHBONE arbiter in front of the UART register slave port.
// Optional strobe timeout abort is compiled in with `define UART_ARB_TIMEOUT_EN.
module uart_wb_arbiter #(
  parameter int ADDR_WIDTH = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  wb_rst_i,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [7:0]            m0_dat_i,
  output logic [7:0]            m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [7:0]            m1_dat_i,
  output logic [7:0]            m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [7:0]            s_dat_o,
  input  logic [7:0]            s_dat_i,
  input  logic                  s_ack_i,
  output logic [1:0]            gnt_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t state_q, state_d;
  logic   lastGnt_q, lastGnt_d;
  logic   tmoHit;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : gBadTimeout
    $error("uart_wb_arbiter: TIMEOUT must be within 2..255");
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] tmoCnt_q, tmoCnt_d;

  // Counts cycles a granted strobe has waited; the last count aborts the grant.
  assign tmoHit = s_stb_o && !s_ack_i && (tmoCnt_q == TMO_LAST);

  always_comb begin
    tmoCnt_d = tmoCnt_q + 8'd1;
    if (!s_stb_o || s_ack_i || tmoHit) tmoCnt_d = '0;
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) tmoCnt_q <= '0;
    else          tmoCnt_q <= tmoCnt_d;
  end
`else
  assign tmoHit = 1'b0;
`endif

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      lastGnt_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      lastGnt_q <= lastGnt_d;
    end
  end

  // On contention the master that was not granted last wins; an owner
  // releasing cyc hands over directly to a waiting master.
  always_comb begin
    state_d   = state_q;
    lastGnt_d = lastGnt_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || lastGnt_q)) begin
          state_d   = GNT0;
          lastGnt_d = 1'b0;
        end else if (m1_cyc_i) begin
          state_d   = GNT1;
          lastGnt_d = 1'b1;
        end
      end
      GNT0: begin
        if (tmoHit) begin
          state_d = IDLE;
        end else if (!m0_cyc_i) begin
          if (m1_cyc_i) begin
            state_d   = GNT1;
            lastGnt_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GNT1: begin
        if (tmoHit) begin
          state_d = IDLE;
        end else if (!m1_cyc_i) begin
          if (m0_cyc_i) begin
            state_d   = GNT0;
            lastGnt_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    gnt_o   = 2'b00;
    unique case (state_q)
      GNT0: begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_cyc_i && m0_stb_i;
        s_we_o  = m0_we_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        gnt_o   = 2'b01;
      end
      GNT1: begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_cyc_i && m1_stb_i;
        s_we_o  = m1_we_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        gnt_o   = 2'b10;
      end
      default: ;
    endcase
  end

  // Acks reach only the current owner, so an ack arriving after release is dropped.
  assign m0_ack_o = s_ack_i && (state_q == GNT0);
  assign m1_ack_o = s_ack_i && (state_q == GNT1);
  assign m0_err_o = tmoHit && (state_q == GNT0);
  assign m1_err_o = tmoHit && (state_q == GNT1);
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_uart_wb_arbiter.sv
// Directed bench for uart_wb_arbiter: grant order, handover, data return, late ack,
// async reset and (with UART_ARB_TIMEOUT_EN) the strobe timeout abort.
module tb_uart_wb_arbiter;

  logic       clk;
  logic       wb_rst_i;
  logic       m0_cyc_i, m0_stb_i, m0_we_i;
  logic [2:0] m0_adr_i;
  logic [7:0] m0_dat_i, m0_dat_o;
  logic       m0_ack_o, m0_err_o;
  logic       m1_cyc_i, m1_stb_i, m1_we_i;
  logic [2:0] m1_adr_i;
  logic [7:0] m1_dat_i, m1_dat_o;
  logic       m1_ack_o, m1_err_o;
  logic       s_cyc_o, s_stb_o, s_we_o;
  logic [2:0] s_adr_o;
  logic [7:0] s_dat_o, s_dat_i;
  logic       s_ack_i;
  logic [1:0] gnt_o;

  int errorCount = 0;
  int checkCount = 0;

  uart_wb_arbiter #(.ADDR_WIDTH(3), .TIMEOUT(16)) dut (
    .clk(clk), .wb_rst_i(wb_rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int m, input logic cyc, input logic stb,
                               input logic we, input logic [2:0] adr,
                               input logic [7:0] dat);
    if (m == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    wb_rst_i = 1'b1;
    s_ack_i  = 1'b0;
    s_dat_i  = 8'h00;
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    tick();
    tick();
    checkOutput("rst_gnt", 8'(gnt_o), 8'h00);
    checkOutput("rst_s_cyc", 8'(s_cyc_o), 8'h00);
    checkOutput("rst_s_stb", 8'(s_stb_o), 8'h00);
    checkOutput("rst_m0_err", 8'(m0_err_o), 8'h00);
    checkOutput("rst_m1_err", 8'(m1_err_o), 8'h00);
    wb_rst_i = 1'b0;

    $display("[TB] single m0 write");
    tick();
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 3'd3, 8'h83);
    #1;
    checkOutput("w_gnt_req_cycle", 8'(gnt_o), 8'h00);
    tick();
    checkOutput("w_gnt", 8'(gnt_o), 8'h01);
    checkOutput("w_s_stb", 8'(s_stb_o), 8'h01);
    checkOutput("w_s_we", 8'(s_we_o), 8'h01);
    checkOutput("w_s_adr", 8'(s_adr_o), 8'h03);
    checkOutput("w_s_dat", s_dat_o, 8'h83);
    checkOutput("w_m0_ack_wait", 8'(m0_ack_o), 8'h00);
    tick();
    s_ack_i = 1'b1; s_dat_i = 8'h5A;
    #1;
    checkOutput("w_m0_ack", 8'(m0_ack_o), 8'h01);
    checkOutput("w_m1_ack", 8'(m1_ack_o), 8'h00);
    checkOutput("w_m0_dat", m0_dat_o, 8'h5A);
    tick();
    s_ack_i = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    #1;
    checkOutput("w_m0_ack_end", 8'(m0_ack_o), 8'h00);
    checkOutput("w_stb_forced", 8'(s_stb_o), 8'h00);
    tick();
    checkOutput("w_idle", 8'(gnt_o), 8'h00);

    $display("[TB] simultaneous requests after reset");
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'd1, 8'h00);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 3'd6, 8'h00);
    tick();
    checkOutput("rr_first_m0", 8'(gnt_o), 8'h01);
    checkOutput("rr_s_adr0", 8'(s_adr_o), 8'h01);
    tick();
    s_ack_i = 1'b1; s_dat_i = 8'h3C;
    #1;
    checkOutput("rr_m0_ack", 8'(m0_ack_o), 8'h01);
    checkOutput("rr_m0_dat", m0_dat_o, 8'h3C);
    checkOutput("rr_m1_noack", 8'(m1_ack_o), 8'h00);
    tick();
    s_ack_i = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    #1;
    checkOutput("rr_handover_gnt", 8'(gnt_o), 8'h01);
    checkOutput("rr_handover_cyc", 8'(s_cyc_o), 8'h00);
    tick();
    checkOutput("rr_direct_m1", 8'(gnt_o), 8'h02);
    checkOutput("rr_s_adr1", 8'(s_adr_o), 8'h06);
    tick();
    s_ack_i = 1'b1;
    #1;
    checkOutput("rr_m1_ack", 8'(m1_ack_o), 8'h01);
    checkOutput("rr_m0_noack", 8'(m0_ack_o), 8'h00);
    tick();
    s_ack_i = 1'b0;
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    tick();
    checkOutput("rr_idle", 8'(gnt_o), 8'h00);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'd1, 8'h00);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 3'd6, 8'h00);
    tick();
    checkOutput("rr_alternate_m0", 8'(gnt_o), 8'h01);

    $display("[TB] m1 burst while m0 waits");
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    tick();
    checkOutput("b_gnt_m1", 8'(gnt_o), 8'h02);
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 3'd4, 8'h99);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 3'd5, 8'h00);
    #1;
    checkOutput("b_s_adr", 8'(s_adr_o), 8'h05);
    tick();
    s_ack_i = 1'b1; s_dat_i = 8'h11;
    #1;
    checkOutput("b_dat1", m1_dat_o, 8'h11);
    checkOutput("b_ack1", 8'(m1_ack_o), 8'h01);
    checkOutput("b_m0_noack1", 8'(m0_ack_o), 8'h00);
    tick();
    s_ack_i = 1'b0;
    #1;
    checkOutput("b_hold_gnt", 8'(gnt_o), 8'h02);
    tick();
    s_ack_i = 1'b1; s_dat_i = 8'h22;
    #1;
    checkOutput("b_dat2", m1_dat_o, 8'h22);
    checkOutput("b_m0_noack2", 8'(m0_ack_o), 8'h00);
    tick();
    s_ack_i = 1'b0;
    tick();
    s_ack_i = 1'b1; s_dat_i = 8'h33;
    #1;
    checkOutput("b_dat3", m1_dat_o, 8'h33);
    checkOutput("b_m0_noack3", 8'(m0_ack_o), 8'h00);
    checkOutput("b_gnt3", 8'(gnt_o), 8'h02);
    tick();
    s_ack_i = 1'b0;
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    #1;
    checkOutput("b_release_stb", 8'(s_stb_o), 8'h00);
    tick();
    checkOutput("b_gnt_m0", 8'(gnt_o), 8'h01);
    checkOutput("b_m0_dat_out", s_dat_o, 8'h99);

    $display("[TB] m0 abandons cycle before ack");
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    #1;
    checkOutput("late_still_gnt", 8'(gnt_o), 8'h01);
    tick();
    s_ack_i = 1'b1;
    #1;
    checkOutput("late_gnt_idle", 8'(gnt_o), 8'h00);
    checkOutput("late_m0_ack", 8'(m0_ack_o), 8'h00);
    checkOutput("late_m1_ack", 8'(m1_ack_o), 8'h00);
    tick();
    s_ack_i = 1'b0;

    $display("[TB] async reset during m1 grant");
    applyStimulus(1, 1'b1, 1'b1, 1'b1, 3'd2, 8'h44);
    tick();
    checkOutput("ar_gnt_m1", 8'(gnt_o), 8'h02);
    checkOutput("ar_s_dat", s_dat_o, 8'h44);
    #2;
    wb_rst_i = 1'b1;
    s_ack_i  = 1'b1;
    #1;
    checkOutput("ar_gnt", 8'(gnt_o), 8'h00);
    checkOutput("ar_s_cyc", 8'(s_cyc_o), 8'h00);
    checkOutput("ar_s_stb", 8'(s_stb_o), 8'h00);
    checkOutput("ar_s_we", 8'(s_we_o), 8'h00);
    checkOutput("ar_s_adr", 8'(s_adr_o), 8'h00);
    checkOutput("ar_s_dat0", s_dat_o, 8'h00);
    checkOutput("ar_m1_ack", 8'(m1_ack_o), 8'h00);
    #1;
    wb_rst_i = 1'b0;
    s_ack_i  = 1'b0;
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00);
    tick();
    checkOutput("ar_last_gnt_m0", 8'(gnt_o), 8'h01);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    tick();
    checkOutput("ar_idle", 8'(gnt_o), 8'h00);

    $display("[TB] slave never acks m0");
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'd7, 8'h00);
    tick();
    checkOutput("to_gnt", 8'(gnt_o), 8'h01);
`ifdef UART_ARB_TIMEOUT_EN
    for (int k = 0; k < 15; k++) begin
      checkOutput("to_err_early", 8'(m0_err_o), 8'h00);
      tick();
    end
    checkOutput("to_err_pulse", 8'(m0_err_o), 8'h01);
    checkOutput("to_err_m1", 8'(m1_err_o), 8'h00);
    checkOutput("to_gnt_at_err", 8'(gnt_o), 8'h01);
    tick();
    checkOutput("to_gnt_idle", 8'(gnt_o), 8'h00);
    checkOutput("to_err_clear", 8'(m0_err_o), 8'h00);
    tick();
    checkOutput("to_rearb", 8'(gnt_o), 8'h01);
`else
    for (int k = 0; k < 110; k++) begin
      checkOutput("hold_err", 8'(m0_err_o), 8'h00);
      tick();
    end
    checkOutput("hold_gnt", 8'(gnt_o), 8'h01);
`endif
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    tick();
    checkOutput("end_idle", 8'(gnt_o), 8'h00);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
